// File: rtl/control_comparador.sv
// Sequential unsigned comparator: scans captured A/B one bit per cycle, LSB first.
// Optional abort input is enabled by defining COMPARADOR_ABORT_EN.
module control_comparador #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
`ifdef COMPARADOR_ABORT_EN
   input  logic         abort,
`endif
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         W_out,
   output logic         EQ
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LastBit = CW'(N - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  a_q, a_d, b_q, b_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          gt_q, gt_d, lt_q, lt_d;
   logic          w_q, w_d, eq_q, eq_d;
   logic          abort_req;
   logic          bit_gt, bit_lt;

`ifdef COMPARADOR_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      w_d     = w_q;
      eq_d    = eq_q;
      bit_gt  = a_q[cnt_q] & ~b_q[cnt_q];
      bit_lt  = ~a_q[cnt_q] & b_q[cnt_q];

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               cnt_d   = '0;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               w_d     = 1'b0;
               eq_d    = 1'b0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (abort_req) begin
               state_d = StIdle;
            end else begin
               // A higher differing bit overrides anything decided below it.
               if (bit_gt || bit_lt) begin
                  gt_d = bit_gt;
                  lt_d = bit_lt;
               end
               if (cnt_q == LastBit) begin
                  w_d     = gt_d;
                  eq_d    = ~gt_d & ~lt_d;
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         w_q     <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         w_q     <= w_d;
         eq_q    <= eq_d;
      end
   end

   assign busy  = (state_q == StScan);
   assign done  = (state_q == StDone);
   assign W_out = w_q;
   assign EQ    = eq_q;

endmodule

// File: tb/tb_control_comparador.sv
// Bench for control_comparador (N=8): vector table, random runs against an
// arithmetic reference, and hand sequences for held start, reset and abort.
module tb_control_comparador;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [N-1:0] A, B;
   logic         busy, done, W_out, EQ;
`ifdef COMPARADOR_ABORT_EN
   logic         abort = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   control_comparador #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
`ifdef COMPARADOR_ABORT_EN
      .abort (abort),
`endif
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .W_out (W_out),
      .EQ    (EQ)
   );

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         w;
      logic         eq;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Full transaction: start for one edge, scramble A/B during scan, check timing and result.
   task automatic run_cmp(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic ew, input logic eeq);
      int edges, bcnt;
      A = a;
      B = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("accept_busy", int'(busy), 1);
      check("accept_clear", int'({W_out, EQ}), 0);
      edges = 1;
      bcnt  = 0;
      while (!done && edges < 20) begin
         bcnt += int'(busy);
         A = N'($urandom);
         B = N'($urandom);
         tick();
         edges++;
      end
      check("done_edge", edges, N + 1);
      check("busy_cycles", bcnt, N);
      check("w_out", int'(W_out), int'(ew));
      check("eq", int'(EQ), int'(eeq));
      tick();
      check("done_fall", int'({done, busy}), 0);
      check("hold_result", int'({W_out, EQ}), int'({ew, eeq}));
   endtask

   vec_t vecs[8];

   initial begin
      int           dcnt, dedge;
      logic [N-1:0] ra, rb;

      vecs[0] = '{8'h5A, 8'h3C, 1'b1, 1'b0};
      vecs[1] = '{8'h81, 8'h81, 1'b0, 1'b1};
      vecs[2] = '{8'h01, 8'h80, 1'b0, 1'b0};
      vecs[3] = '{8'hFF, 8'h00, 1'b1, 1'b0};
      vecs[4] = '{8'h00, 8'hFF, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1};
      vecs[6] = '{8'h80, 8'h7F, 1'b1, 1'b0};
      vecs[7] = '{8'h7E, 8'h7F, 1'b0, 1'b0};

      rst   = 1'b1;
      start = 1'b1;
      A     = 8'hAA;
      B     = 8'h55;
      tick();
      tick();
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_w", int'(W_out), 0);
      check("reset_eq", int'(EQ), 0);
      rst   = 1'b0;
      start = 1'b0;
      tick();

      foreach (vecs[i]) run_cmp(vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].eq);

      for (int i = 0; i < 20; i++) begin
         ra = N'($urandom);
         rb = (i % 5 == 0) ? ra : N'($urandom);
         run_cmp(ra, rb, ra > rb, ra == rb);
      end

      // Reset clears a held result.
      run_cmp(8'h5A, 8'h3C, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_clears_w", int'(W_out), 0);

      // Start held high through a run while A/B change: one result, then re-accept from IDLE.
      A = 8'h3C;
      B = 8'h5A;
      start = 1'b1;
      tick();
      dcnt  = 0;
      dedge = 0;
      for (int e = 2; e <= 10; e++) begin
         A = N'($urandom);
         B = N'($urandom);
         if (e == 10) begin
            A = 8'h10;
            B = 8'h10;
         end
         tick();
         if (done) begin
            dcnt++;
            dedge = e;
            check("held_w", int'(W_out), 0);
            check("held_eq", int'(EQ), 0);
         end
      end
      check("held_done_count", dcnt, 1);
      check("held_done_edge", dedge, N + 1);
      check("held_idle", int'({busy, done}), 0);
      tick();
      start = 1'b0;
      check("held_reaccept", int'(busy), 1);
      for (int e = 0; e < 20 && !done; e++) tick();
      check("held_second_done", int'(done), 1);
      check("held_second_eq", int'({W_out, EQ}), 1);
      tick();

      // Reset in cycle 4 of SCAN, with start also high: abort, no done.
      A = 8'hFF;
      B = 8'h00;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("rst_mid_outputs", int'({busy, done, W_out, EQ}), 0);
      dcnt = 0;
      for (int e = 0; e < 12; e++) begin
         tick();
         dcnt += int'(done) + int'(busy);
      end
      check("rst_mid_no_done", dcnt, 0);

`ifdef COMPARADOR_ABORT_EN
      // Abort in SCAN cycle 3.
      A = 8'h5A;
      B = 8'h3C;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_outputs", int'({busy, done, W_out, EQ}), 0);
      dcnt = 0;
      for (int e = 0; e < 12; e++) begin
         tick();
         dcnt += int'(done);
      end
      check("abort_no_done", dcnt, 0);
      run_cmp(8'hFF, 8'h00, 1'b1, 1'b0);
      // Abort in IDLE does not block acceptance.
      abort = 1'b1;
      A = 8'h01;
      B = 8'h01;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("abort_idle_accept", int'(busy), 1);
      for (int e = 0; e < 20 && !done; e++) tick();
      check("abort_idle_eq", int'({done, EQ}), 3);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_comparador.md
CONTROL_COMPARADOR -- requirements
Module: control_comparador

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits; legal N >= 1.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a comparison; sampled only in IDLE.
REQ-005 SHALL have port A  input  N  first operand; captured on start acceptance.
REQ-006 SHALL have port B  input  N  second operand; captured on start acceptance.
REQ-007 SHALL have port busy  output  1  high while bits are being scanned.
REQ-008 SHALL have port done  output  1  single-cycle completion pulse.
REQ-009 SHALL have port W_out  output  1  result: 1 iff captured A > captured B (unsigned).
REQ-010 SHALL have port EQ  output  1  result: 1 iff captured A == captured B.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-012 SHALL, in IDLE with start=1 at a rising edge, capture A and B into internal registers, clear the bit counter to 0, preset the running result to "equal", and enter SCAN.
REQ-013 SHALL, in SCAN, process one bit per cycle, from bit 0 (LSB) up to bit N-1 (right-to-left).
REQ-014 SHALL, per bit i, keep the running result if A[i]==B[i], otherwise set it to greater (A[i]=1) or less (A[i]=0).
REQ-015 SHALL, on the edge that processes bit N-1, register W_out and EQ from the final running result and enter DONE.
REQ-016 SHALL hold DONE for exactly one cycle with done=1, then return to IDLE.
REQ-017 SHALL drive busy=1 exactly in SCAN; latency from the start edge to done high is N+1 edges, done falling at edge N+2.
REQ-018 SHALL hold W_out and EQ stable from DONE until the next accepted start; both are cleared to 0 on acceptance.
REQ-019 SHALL ignore start in SCAN and DONE (no restart, no queuing).
REQ-020 SHALL ignore changes on A and B after capture.
REQ-021 SHALL size the bit counter to ceil(log2(N)) bits (minimum 1) and never wrap past N-1.
REQ-022 SHALL, for N=1, spend exactly one cycle in SCAN.

Reset
REQ-023 SHALL, on rst=1 at a rising edge, enter IDLE and clear busy, done, W_out, EQ, the counter and the captured operands to 0, in any state.
REQ-024 SHALL give rst priority over start and abort in the same cycle; a comparison interrupted by reset produces no done.

Configuration
REQ-025 SHALL use macro COMPARADOR_ABORT_EN.
REQ-026 SHALL, with COMPARADOR_ABORT_EN defined, add port abort (input, 1 bit); abort=1 in SCAN returns to IDLE at that edge, with no done and W_out/EQ left at 0.
REQ-027 SHALL, with abort=1 in IDLE or DONE, have no effect.
REQ-028 SHALL, without COMPARADOR_ABORT_EN, have no abort port, and every SCAN shall run to completion.

Verification (N=8)
REQ-029 SHALL cover A=8'h5A, B=8'h3C with start for 1 cycle -> busy high 8 cycles; done pulses at edge 9; W_out=1, EQ=0.
REQ-030 SHALL cover A=8'h81, B=8'h81 -> done at edge 9; W_out=0, EQ=1.
REQ-031 SHALL cover A=8'h01, B=8'h80, which differ at LSB and MSB -> MSB decides: W_out=0, EQ=0.
REQ-032 SHALL cover start held high through a whole run with A/B changed mid-scan -> a single result from the captured values; next run accepted only after return to IDLE.
REQ-033 SHALL cover rst asserted in cycle 4 of SCAN -> IDLE next edge, all outputs 0, no done pulse.
REQ-034 SHALL cover, with COMPARADOR_ABORT_EN, abort in SCAN cycle 3 -> IDLE, no done; a subsequent start with A=8'hFF, B=8'h00 -> W_out=1.
